// File: rtl/wb_slave_mux.sv
// Single-master to three-slave Wishbone decoder/mux (RAM, gpio1, gpio2).
// Slave select is registered at cycle start. A watchdog turns a silent slave into an error ack.
module wb_slave_mux #(
  parameter logic [31:0] IO1_BASE  = 32'h3000_0000,
  parameter int unsigned IO1_WORDS = 3,
  parameter logic [31:0] IO2_BASE  = 32'h4000_0000,
  parameter int unsigned IO2_WORDS = 4,
  parameter int unsigned TIMEOUT   = 16,
  parameter logic [31:0] ERR_DATA  = 32'hDEAD_BEEF
) (
  input  logic        wb_clk_i,
  input  logic        wb_rst_ni,
  input  logic [31:0] m_adr_i,
  input  logic [31:0] m_dat_i,
  input  logic [3:0]  m_sel_i,
  input  logic        m_we_i,
  input  logic        m_cyc_i,
  input  logic        m_stb_i,
  output logic [31:0] m_dat_o,
  output logic        m_ack_o,
  output logic [31:0] s_adr_o,
  output logic [31:0] s_dat_o,
  output logic [3:0]  s_sel_o,
  output logic        s_we_o,
  output logic        s_cyc_o,
  output logic [2:0]  s_stb_o,
  input  logic [31:0] s0_dat_i,
  input  logic [31:0] s1_dat_i,
  input  logic [31:0] s2_dat_i,
  input  logic [2:0]  s_ack_i,
  input  logic        err_clr_i,
  output logic        bus_err_o,
  output logic [31:0] err_adr_o
);

  localparam int TW = $clog2(TIMEOUT);
  localparam logic [TW-1:0] TLAST = TW'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ACTIVE, ERR} state_e;

  state_e        state_q, state_d;
  logic [1:0]    sel_q, sel_d;
  logic [TW-1:0] timer_q, timer_d;
  logic          bus_err_q;
  logic [31:0]   err_adr_q;

  logic [31:0] off1, off2;
  logic [1:0]  dec_sel;
  logic [2:0]  sel_oh;
  logic        sel_ack;
  logic [31:0] sel_dat;

  assign s_adr_o = m_adr_i;
  assign s_dat_o = m_dat_i;
  assign s_sel_o = m_sel_i;
  assign s_we_o  = m_we_i;
  assign s_cyc_o = m_cyc_i;

  // Offsets wrap below the base, so addresses under a window never hit it.
  always_comb begin
    off1    = m_adr_i - IO1_BASE;
    off2    = m_adr_i - IO2_BASE;
    dec_sel = 2'd0;
    if (off1[31:2] < 30'(IO1_WORDS))      dec_sel = 2'd1;
    else if (off2[31:2] < 30'(IO2_WORDS)) dec_sel = 2'd2;
  end

  always_comb begin
    sel_oh  = 3'b001;
    sel_ack = s_ack_i[0];
    sel_dat = s0_dat_i;
    case (sel_q)
      2'd1:    begin sel_oh = 3'b010; sel_ack = s_ack_i[1]; sel_dat = s1_dat_i; end
      2'd2:    begin sel_oh = 3'b100; sel_ack = s_ack_i[2]; sel_dat = s2_dat_i; end
      default: ;
    endcase
  end

  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      state_q <= IDLE;
      sel_q   <= '0;
      timer_q <= '0;
    end else begin
      state_q <= state_d;
      sel_q   <= sel_d;
      timer_q <= timer_d;
    end
  end

  always_comb begin
    state_d = state_q;
    sel_d   = sel_q;
    timer_d = timer_q;
    case (state_q)
      IDLE: if (m_cyc_i && m_stb_i) begin
        sel_d   = dec_sel;
        timer_d = '0;
        state_d = ACTIVE;
      end
      ACTIVE: begin
        // An ack on the last allowed cycle still completes normally.
        if (sel_ack || !m_cyc_i)   state_d = IDLE;
        else if (timer_q == TLAST) state_d = ERR;
        else                       timer_d = timer_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    s_stb_o = '0;
    m_ack_o = 1'b0;
    m_dat_o = '0;
    case (state_q)
      ACTIVE: begin
        s_stb_o = (m_cyc_i && m_stb_i) ? sel_oh : 3'b000;
        m_ack_o = sel_ack;
        m_dat_o = sel_ack ? sel_dat : 32'h0;
      end
      ERR: begin
        m_ack_o = 1'b1;
        m_dat_o = ERR_DATA;
      end
      default: ;
    endcase
  end

  // Setting the flag takes precedence over a simultaneous clear.
  always_ff @(posedge wb_clk_i or negedge wb_rst_ni) begin
    if (!wb_rst_ni) begin
      bus_err_q <= 1'b0;
      err_adr_q <= '0;
    end else if (state_q == ERR) begin
      bus_err_q <= 1'b1;
      err_adr_q <= m_adr_i;
    end else if (err_clr_i) begin
      bus_err_q <= 1'b0;
    end
  end

  assign bus_err_o = bus_err_q;
  assign err_adr_o = err_adr_q;

endmodule

// File: tb/tb_wb_slave_mux.sv
// Bench for wb_slave_mux: vector table, hand-written corner sequences and random transactions
// checked against a transaction-level model of decode, ack timing and error status.
module tb_wb_slave_mux;
  localparam int TO = 16;
  localparam logic [31:0] DEAD = 32'hDEAD_BEEF;

  logic        clk = 1'b0, rst_n = 1'b0;
  logic [31:0] m_adr = '0, m_dat_w = '0;
  logic [3:0]  m_sel = '0;
  logic        m_we = 1'b0, m_cyc = 1'b0, m_stb = 1'b0;
  logic [31:0] m_dat_o;
  logic        m_ack_o;
  logic [31:0] s_adr_o, s_dat_o;
  logic [3:0]  s_sel_o;
  logic        s_we_o, s_cyc_o;
  logic [2:0]  s_stb_o;
  logic [31:0] s0_dat = '0, s1_dat = '0, s2_dat = '0;
  logic [2:0]  s_ack = '0;
  logic        err_clr = 1'b0;
  logic        bus_err_o;
  logic [31:0] err_adr_o;

  always #5 clk = ~clk;

  wb_slave_mux dut (
    .wb_clk_i(clk), .wb_rst_ni(rst_n),
    .m_adr_i(m_adr), .m_dat_i(m_dat_w), .m_sel_i(m_sel), .m_we_i(m_we),
    .m_cyc_i(m_cyc), .m_stb_i(m_stb), .m_dat_o(m_dat_o), .m_ack_o(m_ack_o),
    .s_adr_o(s_adr_o), .s_dat_o(s_dat_o), .s_sel_o(s_sel_o), .s_we_o(s_we_o),
    .s_cyc_o(s_cyc_o), .s_stb_o(s_stb_o),
    .s0_dat_i(s0_dat), .s1_dat_i(s1_dat), .s2_dat_i(s2_dat), .s_ack_i(s_ack),
    .err_clr_i(err_clr), .bus_err_o(bus_err_o), .err_adr_o(err_adr_o)
  );

  int total = 0, bad = 0;
  logic        mdl_err = 1'b0;
  logic [31:0] mdl_adr = '0;

  typedef struct {
    logic [31:0] adr;
    logic        we;
    int          delay;   // ACTIVE cycle index of the slave ack; >= TO means never
    logic [31:0] dat;
    logic [2:0]  stray;   // acks from other slaves, held for the whole transaction
    int          exp_sel;
  } vec_t;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic step();
    @(posedge clk); #1;
  endtask

  task automatic mid();
    @(negedge clk);
  endtask

  // Address windows from the memory map, as byte ranges.
  function automatic int model_sel(input logic [31:0] a);
    if (a >= 32'h3000_0000 && a < 32'h3000_0000 + 4 * 3) return 1;
    if (a >= 32'h4000_0000 && a < 32'h4000_0000 + 4 * 4) return 2;
    return 0;
  endfunction

  // Entered and left at posedge+1 with the DUT in IDLE.
  task automatic txn(input logic [31:0] adr, input logic we, input int delay,
                     input logic [31:0] dat, input logic [2:0] stray, input int sel,
                     input logic clr_in_err);
    logic [2:0] oh;
    bit acked;
    oh = 3'(1 << sel);
    acked = 1'b0;
    m_adr = adr; m_we = we; m_dat_w = $urandom; m_sel = 4'hF;
    m_cyc = 1'b1; m_stb = 1'b1; s_ack = stray;
    mid();
    chk("idle_stb", 32'(s_stb_o), 32'h0);
    chk("idle_ack", 32'(m_ack_o), 32'h0);
    chk("pass_adr", s_adr_o, adr);
    for (int k = 0; k < TO && !acked; k++) begin
      step();
      s0_dat = $urandom; s1_dat = $urandom; s2_dat = $urandom;
      case (sel)
        1: s1_dat = dat;
        2: s2_dat = dat;
        default: s0_dat = dat;
      endcase
      s_ack = (stray & ~oh) | ((k == delay) ? oh : 3'b000);
      mid();
      chk($sformatf("act_stb[%0d]", k), 32'(s_stb_o), 32'(oh));
      chk($sformatf("act_ack[%0d]", k), 32'(m_ack_o), (k == delay) ? 32'h1 : 32'h0);
      chk($sformatf("act_dat[%0d]", k), m_dat_o, (k == delay) ? dat : 32'h0);
      if (k == delay) acked = 1'b1;
    end
    if (!acked) begin
      step();
      s_ack = oh | stray;
      err_clr = clr_in_err;
      mid();
      chk("err_ack", 32'(m_ack_o), 32'h1);
      chk("err_dat", m_dat_o, DEAD);
      chk("err_stb", 32'(s_stb_o), 32'h0);
      mdl_err = 1'b1;
      mdl_adr = adr;
    end
    step();
    m_cyc = 1'b0; m_stb = 1'b0; err_clr = 1'b0;
    s_ack = oh | stray;
    mid();
    chk("post_ack", 32'(m_ack_o), 32'h0);
    chk("post_dat", m_dat_o, 32'h0);
    chk("post_stb", 32'(s_stb_o), 32'h0);
    chk("bus_err", 32'(bus_err_o), 32'(mdl_err));
    chk("err_adr", err_adr_o, mdl_adr);
    step();
    s_ack = '0;
  endtask

  vec_t vecs[9];

  initial begin
    vecs[0] = '{32'h0000_0100, 1'b0, 2,  32'h1234_5678, 3'b000, 0};
    vecs[1] = '{32'h3000_0008, 1'b1, 0,  32'h0000_0011, 3'b000, 1};
    vecs[2] = '{32'h3000_000C, 1'b1, 1,  32'h0000_0022, 3'b000, 0};
    vecs[3] = '{32'h2FFF_FFFC, 1'b0, 0,  32'h0000_0033, 3'b000, 0};
    vecs[4] = '{32'h4000_000C, 1'b0, 3,  32'hA5A5_0001, 3'b001, 2};
    vecs[5] = '{32'h3000_0000, 1'b0, 15, 32'h0BAD_F00D, 3'b000, 1};
    vecs[6] = '{32'h5000_0000, 1'b0, 99, 32'h0,         3'b000, 0};
    vecs[7] = '{32'h4000_0010, 1'b0, 0,  32'h0000_0044, 3'b100, 0};
    vecs[8] = '{32'h3FFF_FFFC, 1'b0, 5,  32'h0000_0055, 3'b110, 0};

    #2;
    chk("rst_ack", 32'(m_ack_o), 32'h0);
    chk("rst_dat", m_dat_o, 32'h0);
    chk("rst_stb", 32'(s_stb_o), 32'h0);
    chk("rst_err", 32'(bus_err_o), 32'h0);
    chk("rst_adr", err_adr_o, 32'h0);
    step();
    rst_n = 1'b1;
    step();

    foreach (vecs[i]) begin
      chk($sformatf("decode_%0d", i), 32'(model_sel(vecs[i].adr)), 32'(vecs[i].exp_sel));
      txn(vecs[i].adr, vecs[i].we, vecs[i].delay, vecs[i].dat, vecs[i].stray,
          vecs[i].exp_sel, 1'b0);
    end

    // Second timeout with a clear in the error cycle: the set must win.
    txn(32'h0000_0040, 1'b0, 99, 32'h0, 3'b000, 0, 1'b1);
    // Clear on its own drops the flag but keeps the address.
    err_clr = 1'b1;
    step();
    err_clr = 1'b0;
    mdl_err = 1'b0;
    mid();
    chk("clr_err", 32'(bus_err_o), 32'h0);
    chk("clr_adr", err_adr_o, 32'h0000_0040);
    step();

    // Master abandons the cycle in the third ACTIVE cycle.
    m_adr = 32'h0000_0200; m_cyc = 1'b1; m_stb = 1'b1;
    step(); step(); step();
    m_cyc = 1'b0; m_stb = 1'b0;
    mid();
    chk("drop_stb", 32'(s_stb_o), 32'h0);
    chk("drop_ack", 32'(m_ack_o), 32'h0);
    for (int k = 0; k < TO + 2; k++) begin
      step();
      mid();
      chk("drop_noack", 32'(m_ack_o), 32'h0);
    end
    chk("drop_err", 32'(bus_err_o), 32'h0);
    step();

    // Set the flag again, then reset in the middle of an ACTIVE cycle.
    txn(32'h5000_0000, 1'b0, 99, 32'h0, 3'b000, 0, 1'b0);
    m_adr = 32'h0000_0100; m_cyc = 1'b1; m_stb = 1'b1;
    step(); step(); step();
    s_ack = 3'b111; s0_dat = 32'hFFFF_FFFF;
    rst_n = 1'b0;
    #1;
    chk("mrst_ack", 32'(m_ack_o), 32'h0);
    chk("mrst_dat", m_dat_o, 32'h0);
    chk("mrst_stb", 32'(s_stb_o), 32'h0);
    chk("mrst_err", 32'(bus_err_o), 32'h0);
    chk("mrst_adr", err_adr_o, 32'h0);
    mdl_err = 1'b0; mdl_adr = '0;
    m_cyc = 1'b0; m_stb = 1'b0; s_ack = '0;
    step();
    rst_n = 1'b1;
    step();
    txn(32'h0000_0100, 1'b0, 2, 32'h1234_5678, 3'b000, 0, 1'b0);

    // Random transactions against the model.
    for (int n = 0; n < 40; n++) begin
      logic [31:0] a;
      int d;
      case ($urandom_range(0, 3))
        0: a = 32'h3000_0000 - 32'd8 + 32'(4 * $urandom_range(0, 5));
        1: a = 32'h4000_0000 - 32'd8 + 32'(4 * $urandom_range(0, 7));
        2: a = $urandom & 32'hFFFF_FFFC;
        default: a = 32'(4 * $urandom_range(0, 255));
      endcase
      d = ($urandom_range(0, 5) == 0) ? $urandom_range(TO, TO + 4) : $urandom_range(0, 4);
      txn(a, 1'($urandom), d, $urandom, 3'($urandom), model_sel(a), 1'($urandom));
      if ($urandom_range(0, 4) == 0) begin
        err_clr = 1'b1;
        step();
        err_clr = 1'b0;
        mdl_err = 1'b0;
        mid();
        chk("rnd_clr", 32'(bus_err_o), 32'h0);
        step();
      end
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
